// File: rtl/stream_mux_arb.sv
// stream_mux_arb: two-input round-robin stream mux with a registered output stage.
// Define STREAM_MUX_ARB_LOCK_EN to keep a packet's beats together until its last beat.
module stream_mux_arb #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);
    logic prio, load, any, grant, elig0, elig1;
`ifdef STREAM_MUX_ARB_LOCK_EN
    logic lock, lock_src;
    always_comb begin
        elig0 = in0_valid && !(lock && lock_src);
        elig1 = in1_valid && !(lock && !lock_src);
    end
    // the winning beat's last flag decides whether the packet stays locked
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock     <= 1'b0;
            lock_src <= 1'b0;
        end else if (load && any) begin
            lock     <= !(grant ? in1_last : in0_last);
            lock_src <= grant;
        end
    end
`else
    always_comb begin
        elig0 = in0_valid;
        elig1 = in1_valid;
    end
`endif
    always_comb begin
        load      = !out_valid || out_ready;
        any       = elig0 || elig1;
        grant     = (elig0 && elig1) ? prio : elig1;
        in0_ready = rst_n && load && any && !grant;
        in1_ready = rst_n && load && any && grant;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
            prio      <= 1'b0;
        end else if (load) begin
            out_valid <= any;
            if (any) begin
                out_data <= grant ? in1_data : in0_data;
                out_last <= grant ? in1_last : in0_last;
                out_src  <= grant;
                prio     <= !grant;
            end
        end
    end
endmodule

// File: doc/stream_mux_arb.md
# stream_mux_arb

Two-input valid/ready stream multiplexer with round-robin arbitration and a registered output stage. It generates the select for the 2:1 data mux internally and presents the chosen beat one cycle later on a single output stream. It sits directly upstream of the combinational mux/gate stages and feeds them registered, arbitrated data plus the source index.

## Interface
- `WIDTH`, 8: data width of each input and the output.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous, active-low reset.
- `in0_valid`, `in1_valid`  input  1  source i has a beat.
- `in0_data`, `in1_data`  input  WIDTH  source i payload.
- `in0_last`, `in1_last`  input  1  final beat of a packet from source i.
- `in0_ready`, `in1_ready`  output  1  beat from source i accepted this cycle.
- `out_valid`  output  1  output register holds a beat.
- `out_data`  output  WIDTH  held payload.
- `out_last`  output  1  held last flag.
- `out_src`  output  1  index of the source of the held beat.
- `out_ready`  input  1  downstream accepts the held beat.

## Operation
- Load enable: `load = !out_valid || out_ready`. This is combinational, with no skid buffer.
- Priority pointer `prio` (1 bit) names the preferred input. Reset value: 0.
- Grant selection:
  - If both inputs are valid (and eligible), grant `prio`.
  - If only one is valid, grant that one.
  - If neither is valid, there is no grant.
- `inX_ready = load && grant==X`. Ready is only ever high for one input. `inX_ready` may be high while `inX_valid` is low only if X is the granted index. Implementations must drive ready to 0 for a non-granted input.
- Transfer from input i is `in_i_valid && in_i_ready`. On a transfer:
  - `out_data`, `out_last` and `out_src` load from input i.
  - `out_valid` is set to 1.
  - `prio` becomes `!i`.
- If `load` is high and there is no transfer, `out_valid` is cleared to 0. `out_data`, `out_last` and `out_src` hold their previous values.
- If `load` is low, all output registers and `prio` hold.
- Output stability: while `out_valid && !out_ready`, `out_data`, `out_last` and `out_src` must not change.
- Inputs are never dropped or duplicated. Each accepted beat appears exactly once on the output, in acceptance order.

## Timing
- Latency: a beat accepted at edge N is visible on the outputs after edge N, i.e. one cycle.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Round-robin fairness: with both inputs continuously valid and `out_ready=1`, grants alternate 0,1,0,1,…
- Simultaneous pop and push: if `out_valid && out_ready` and an input is valid in the same cycle, the new beat replaces the old one at the edge, with no bubble.
- Reset values while `rst_n=0` at an edge:
  - `out_valid=0`, `out_data=0`, `out_last=0`, `out_src=0`.
  - `prio=0`, lock state cleared.
  - `in0_ready=in1_ready=0` combinationally while reset is low.
- Reset mid-operation: a held beat is discarded, and an active packet lock is released.

## Configuration
- Macro: `STREAM_MUX_ARB_LOCK_EN`.
- Defined (packet lock):
  - Accepting a beat from input i with `last=0` sets `lock=1` and `lock_src=i`.
  - While locked, only `lock_src` is eligible for grant, even if the other input is valid and preferred. `prio` still updates per transfer.
  - Accepting a beat from `lock_src` with `last=1` clears `lock`.
  - Packets from the two sources never interleave on the output.
- Undefined: there is no lock state. Arbitration is per beat, and `last` is passed through only.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with both inputs valid and `out_ready=1` -> `out_valid=0`, both readies 0, `out_data=0`. After release, the first output beat has `out_src=0`.
- Single source: `in1` sends 0x11, 0x22, 0x33 back to back, `out_ready=1` -> output 0x11, 0x22, 0x33 on consecutive cycles, 1 cycle late, `out_src=1`.
- Contention: both inputs valid, `in0=0xA0+k`, `in1=0xB0+k`, `out_ready=1`, 6 cycles -> outputs A0, B0, A1, B1, A2, B2.
- Backpressure: `out_ready=0` for 4 cycles while holding 0x5C -> `out_data` stays 0x5C, both readies 0. When `out_ready=1`, 0x5C pops and the next beat loads in the same cycle.
- Lock, with the macro defined: `in0` sends a 3-beat packet (last on beat 3) while `in1` is valid throughout -> output is in0 ×3, then in1. Without the macro, the output interleaves in0, in1, in0, in1, in0.
- Reset mid-packet: under lock, assert `rst_n=0` after beat 1 of 3 -> lock is released and `out_valid=0`. After release, contention starts again from `prio=0`.
